// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared constants and types for the handshake round-robin arbiter.
package handshake_rr_arbiter_pkg;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEFAULT_N     = 3;
  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_PTR_W = ptr_width(DEFAULT_N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: first set bit of valid_i starting at ptr_i,
// wrapping modulo N. Purely combinational.
module rr_priority_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o
);

  logic [31:0]  cand;
  logic [N-1:0] vshift;
  logic         found;

  // Walk candidates ptr, ptr+1, ... (mod N) and keep the first valid one.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    vshift  = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand   = (32'(ptr_i) + k) % N;
      vshift = valid_i >> cand;
      if (!found && vshift[0]) begin
        grant_o = N'(1) << cand;
        idx_o   = PW'(cand);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// N-to-1 valid/ready round-robin arbiter with a single output register.
// Optional checkers: define HANDSHAKE_RR_ARBITER_ASSERT_EN.
module handshake_rr_arbiter
  import handshake_rr_arbiter_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESETN,
  input  logic [N-1:0]              req_valid,
  input  logic [N*WIDTH-1:0]        req_data,
  output logic [N-1:0]              req_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [ptr_width(N)-1:0]   out_src,
  input  logic                      out_ready
);

  localparam int unsigned PW = ptr_width(N);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [PW-1:0]    src_q, src_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [N-1:0]     grant;
  logic [PW-1:0]    win_idx;
  logic [WIDTH-1:0] sel_data;
  logic             in_xfer;
  logic             out_xfer;

  rr_priority_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  // Ready goes to the winner only when the register can accept a beat;
  // reset gates it directly so it is low regardless of CLK.
  always_comb begin
    req_ready = '0;
    if (ASYNCRESETN && ((state_q == EMPTY) || out_ready)) begin
      req_ready = grant;
    end
  end

  // Mux the winning requester's payload.
  always_comb begin
    sel_data = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (win_idx == PW'(j)) begin
        sel_data = req_data[j*WIDTH +: WIDTH];
      end
    end
  end

  assign in_xfer  = |req_ready;
  assign out_xfer = (state_q == FULL) && out_ready;

  // Next state: a fill wins over a drain (same-cycle drain+fill stays FULL).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (in_xfer) begin
      state_d = FULL;
      data_d  = sel_data;
      src_d   = win_idx;
      ptr_d   = (win_idx == PW'(N-1)) ? '0 : win_idx + PW'(1);
    end else if (out_xfer) begin
      state_d = EMPTY;
    end
  end

  // Output register and priority pointer.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

`ifdef HANDSHAKE_RR_ARBITER_ASSERT_EN
  logic [PW+1:0] wait_q [N];

  // Count transfers granted to others while each requester keeps valid high.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int unsigned i = 0; i < N; i++) wait_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!req_valid[i] || req_ready[i]) begin
          wait_q[i] <= '0;
        end else if (in_xfer && (wait_q[i] <= (PW+2)'(N))) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end

  a_ready_onehot0: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    $onehot0(req_ready));

  a_out_stall: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_src));

  for (genvar g = 0; g < N; g++) begin : g_req_chk
    a_req_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      req_valid[g] && !req_ready[g] |=>
        req_valid[g] && $stable(req_data[g*WIDTH +: WIDTH]));

    a_no_starve: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      wait_q[g] <= (PW+2)'(N));
  end
`else
  // Default build carries no checkers.
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed test for handshake_rr_arbiter (N=3, WIDTH=4).
module tb_handshake_rr_arbiter;

  logic        CLK;
  logic        ASYNCRESETN;
  logic [2:0]  req_valid;
  logic [11:0] req_data;
  logic [2:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  handshake_rr_arbiter #(
    .N     (3),
    .WIDTH (4)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_ready   (out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    req_valid   = 3'b111;
    req_data    = 12'h321;
    out_ready   = 1'b1;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_src",   32'(out_src),   32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge CLK);
    #3;
    ASYNCRESETN = 1'b1;
    #1;

    // Fairness: all requesters, out_ready high, pointer starts at 0.
    for (int k = 0; k < 6; k++) begin
      check("rr_ready", 32'(req_ready), 32'(3'b001 << (k % 3)));
      tick();
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_src",   32'(out_src),   32'(k % 3));
      check("rr_data",  32'(out_data),  32'(k % 3 + 1));
    end
    req_valid = 3'b000;
    #1;
    check("idle_ready", 32'(req_ready), 32'd0);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data_hold", 32'(out_data), 32'd3);
    check("drain_src_hold",  32'(out_src),  32'd2);

    // Single requester 1 with data A (pointer at 0).
    req_valid = 3'b010;
    req_data  = 12'h0A0;
    #1;
    check("single_ready", 32'(req_ready), 32'b010);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'hA);
    check("single_src",   32'(out_src),   32'd1);
    req_valid = 3'b000;
    tick();
    check("single_drain", 32'(out_valid), 32'd0);

    // Wrap and skip: pointer=2, valid=011 -> requester 0, pointer becomes 1.
    req_valid = 3'b011;
    req_data  = 12'h321;
    #1;
    check("wrap_ready", 32'(req_ready), 32'b001);
    tick();
    check("wrap_src",  32'(out_src),  32'd0);
    check("wrap_data", 32'(out_data), 32'd1);
    check("wrap_ptr_ready", 32'(req_ready), 32'b010);
    tick();
    check("wrap2_src",  32'(out_src),  32'd1);
    check("wrap2_data", 32'(out_data), 32'd2);

    // Backpressure: load 5 from requester 0 (pointer=2), then stall.
    req_valid = 3'b001;
    req_data  = 12'h765;
    #1;
    check("bp_fill_ready", 32'(req_ready), 32'b001);
    tick();
    check("bp_fill_data", 32'(out_data), 32'h5);
    out_ready = 1'b0;
    req_valid = 3'b110;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready_low", 32'(req_ready), 32'd0);
      tick();
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_data_hold",  32'(out_data),  32'h5);
      check("bp_src_hold",   32'(out_src),   32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b010);
    tick();
    check("bp_next_data", 32'(out_data), 32'h6);
    check("bp_next_src",  32'(out_src),  32'd1);

    // Dropped valid: requester 1 picked but stalled, then withdraws.
    out_ready = 1'b0;
    req_valid = 3'b010;
    req_data  = 12'h090;
    #1;
    check("drop_stall_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 3'b000;
    out_ready = 1'b1;
    #1;
    check("drop_ready", 32'(req_ready), 32'd0);
    tick();
    check("drop_valid", 32'(out_valid), 32'd0);
    check("drop_data",  32'(out_data),  32'h6);
    req_valid = 3'b111;
    req_data  = 12'h321;
    #1;
    check("drop_ptr_hold", 32'(req_ready), 32'b100);
    tick();
    check("drop_refill_src", 32'(out_src), 32'd2);

    // Reset mid-beat while FULL and stalled.
    out_ready = 1'b0;
    #1;
    ASYNCRESETN = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_src",   32'(out_src),   32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    #2;
    ASYNCRESETN = 1'b1;
    out_ready   = 1'b1;
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_ptr",   32'(req_ready), 32'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_rr_arbiter.md
HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 3: number of requester handshake channels.
REQ-002 SHALL have parameter WIDTH, default 4: payload width per beat.
REQ-003 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-004 SHALL have port ASYNCRESETN, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, N: per-requester valid.
REQ-006 SHALL have port req_data, input, N x WIDTH: per-requester payload.
REQ-007 SHALL have port req_ready, output, N: per-requester ready, one-hot or zero.
REQ-008 SHALL have port out_valid, output, 1: shared output channel valid.
REQ-009 SHALL have port out_data, output, WIDTH: shared output channel payload.
REQ-010 SHALL have port out_src, output, clog2(N): index of the requester that supplied the current out_data.
REQ-011 SHALL have port out_ready, input, 1: downstream ready.

Function
REQ-012 SHALL hold one output register (out_valid/out_data/out_src) with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define a transfer on any channel as valid & ready high at a rising CLK edge.
REQ-014 SHALL compute the grant combinationally each cycle: the first requester with req_valid=1, searching from the priority pointer upward modulo N.
REQ-015 SHALL assert req_ready only for the granted requester, and only when the register is EMPTY or out_ready=1 (drain and fill in the same cycle).
REQ-016 SHALL set req_ready to all-zero when no req_valid is high.
REQ-017 SHALL, on a requester transfer, load req_data and the index into out_data/out_src and set out_valid=1 at that edge (latency 1 cycle, input to output).
REQ-018 SHALL, on an output transfer with no simultaneous requester transfer, clear out_valid (FULL->EMPTY); out_data and out_src hold their values.
REQ-019 SHALL, on a requester transfer only, set the pointer to (winner+1) mod N, wrapping from N-1 to 0; otherwise the pointer holds.
REQ-020 SHALL sustain one beat per cycle when out_ready stays high and any req_valid is high.
REQ-021 SHALL keep out_valid, out_data and out_src stable while FULL and out_ready=0.
REQ-022 SHALL not lock a grant: the grant is recomputed every cycle, and a requester that drops valid before its transfer loses that grant with no side effect.

Reset
REQ-023 SHALL, while ASYNCRESETN=0, force out_valid=0, out_data=0, out_src=0, pointer=0, and req_ready all-zero, independent of CLK.
REQ-024 SHALL discard a pending FULL beat when reset asserts mid-operation, and SHALL resume in EMPTY with requester 0 at highest priority.

Configuration
REQ-025 SHALL, with macro HANDSHAKE_RR_ARBITER_ASSERT_EN defined, compile in concurrent assertions clocked on CLK and disabled during reset:
- req_valid held until its transfer, with req_data stable;
- req_ready at most one-hot;
- out_valid/out_data stable while stalled;
- no requester ungranted for more than N consecutive transfers while its valid is held.
REQ-026 SHALL, without the macro, contain no assertion logic, with identical functional behaviour.

Structure
REQ-027 SHALL place the default N/WIDTH constants, the EMPTY/FULL state enum and a pointer-width localparam in package handshake_rr_arbiter_pkg.
REQ-028 SHALL implement the rotating priority search in one sub-module, rr_priority_pick: inputs valid vector and pointer, outputs one-hot grant and index; purely combinational.

Verification
REQ-029 SHALL cover reset defaults: ASYNCRESETN low mid-beat with out_valid=1 -> out_valid=0, out_data=0, pointer=0 immediately, before the next CLK edge.
REQ-030 SHALL cover a single requester: req_valid=3'b010, data 4'hA, out_ready=1 -> req_ready=3'b010, then out_data=4'hA, out_src=1 one cycle later.
REQ-031 SHALL cover round-robin fairness: all req_valid=1, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,0,1,2, one beat per cycle.
REQ-032 SHALL cover backpressure: FULL with out_data=4'h5 and out_ready=0 for 3 cycles -> req_ready=0, out_data holds 4'h5; out_ready=1 -> next beat loads that same cycle.
REQ-033 SHALL cover wrap-around and skip: pointer=2, req_valid=3'b011 -> requester 0 granted, pointer becomes 1.
REQ-034 SHALL cover a dropped valid: requester 1 granted but out_ready=0, then req_valid[1] drops -> no transfer; with ASSERT_EN defined the hold assertion fires.
